// File: rtl/compute_sched_pkg.sv
// ============================================================================
// Module      : compute_sched_pkg
// Description : Shared opcodes, FSM encoding and data width for compute_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package compute_sched_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_MUL   = 2'b01;
    localparam logic [1:0] OP_MAC   = 2'b10;
    localparam logic [1:0] OP_RDCLR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/eight_bit_full_adder_module.sv
// ============================================================================
// Module      : eight_bit_full_adder_module
// Description : 8-bit ripple-style adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eight_bit_full_adder_module (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

`default_nettype wire

// File: rtl/eight_bit_multiplier_module.sv
// ============================================================================
// Module      : eight_bit_multiplier_module
// Description : 8x8 unsigned multiplier with full 16-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eight_bit_multiplier_module (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    assign product = {8'd0, a} * {8'd0, b};

endmodule

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin picker; on a tie the requester not granted
//               last wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic win_valid,
    output logic win_id
);

    assign win_valid = req0 | req1;
    assign win_id    = (req0 & req1) ? ~last_gnt : req1;

endmodule

`default_nettype wire

// File: rtl/compute_scheduler.sv
// ============================================================================
// Module      : compute_scheduler
// Description : Round-robin scheduler sharing one adder and one multiplier
//               between two requesters. MAC/RDCLR and the per-requester
//               accumulators exist only when COMPUTE_SCHED_MAC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module compute_scheduler
    import compute_sched_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done,
    output logic              done_id,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              err
);

    state_t              r_state;
    state_t              w_next_state;

    logic                r_id;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_last_gnt;
    logic [DATA_W-1:0]   r_result;
    logic                r_cout;
    logic                r_err;
    logic                r_done_id;

    logic                w_win_valid;
    logic                w_win_id;
    logic                w_capture;
    logic                w_fin;
    logic [DATA_W-1:0]   w_res;
    logic                w_co;
    logic                w_er;
    logic [DATA_W-1:0]   w_add_a;
    logic [DATA_W-1:0]   w_add_b;
    logic [DATA_W-1:0]   w_sum;
    logic                w_add_cout;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_unused_prod_hi;

`ifdef COMPUTE_SCHED_MAC_EN
    logic [DATA_W-1:0]   r_acc0;
    logic [DATA_W-1:0]   r_acc1;
    logic [DATA_W-1:0]   r_p;
    logic [DATA_W-1:0]   w_acc_sel;
    logic                w_acc_wr;
    logic                w_acc_clr;

    assign w_acc_sel = r_id ? r_acc1 : r_acc0;
`endif

    assign w_unused_prod_hi = w_product[2*DATA_W-1:DATA_W];

    rr_arbiter2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (r_last_gnt),
        .win_valid (w_win_valid),
        .win_id    (w_win_id)
    );

    eight_bit_full_adder_module u_add (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_add_cout)
    );

    eight_bit_multiplier_module u_mul (
        .a       (r_a),
        .b       (r_b),
        .product (w_product)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, adder input steering and the value latched on entry to DONE.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_fin        = 1'b0;
        w_res        = '0;
        w_co         = 1'b0;
        w_er         = 1'b0;
        w_add_a      = r_a;
        w_add_b      = r_b;
`ifdef COMPUTE_SCHED_MAC_EN
        w_acc_wr     = 1'b0;
        w_acc_clr    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_DONE;
                w_fin        = 1'b1;
                case (r_op)
                    OP_ADD: begin
                        w_res = w_sum;
                        w_co  = w_add_cout;
                    end
                    OP_MUL: begin
                        w_res = w_product[DATA_W-1:0];
                    end
`ifdef COMPUTE_SCHED_MAC_EN
                    OP_MAC: begin
                        w_fin        = 1'b0;
                        w_next_state = S_ACC;
                    end
                    default: begin
                        w_res     = w_acc_sel;
                        w_acc_clr = 1'b1;
                    end
`else
                    default: begin
                        w_er = 1'b1;
                    end
`endif
                endcase
            end
`ifdef COMPUTE_SCHED_MAC_EN
            S_ACC: begin
                w_add_a      = r_p;
                w_add_b      = w_acc_sel;
                w_res        = w_sum;
                w_co         = w_add_cout;
                w_acc_wr     = 1'b1;
                w_fin        = 1'b1;
                w_next_state = S_DONE;
            end
`endif
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_id       <= 1'b0;
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_last_gnt <= 1'b1;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_err      <= 1'b0;
            r_done_id  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_id       <= w_win_id;
                r_last_gnt <= w_win_id;
                r_op       <= w_win_id ? op1 : op0;
                r_a        <= w_win_id ? a1  : a0;
                r_b        <= w_win_id ? b1  : b0;
            end
            if (w_fin) begin
                r_result  <= w_res;
                r_cout    <= w_co;
                r_err     <= w_er;
                r_done_id <= r_id;
            end
        end
    end

`ifdef COMPUTE_SCHED_MAC_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc0 <= '0;
            r_acc1 <= '0;
            r_p    <= '0;
        end else begin
            if (r_state == S_EXEC && r_op == OP_MAC) begin
                r_p <= w_product[DATA_W-1:0];
            end
            if (w_acc_clr || w_acc_wr) begin
                if (r_id) begin
                    r_acc1 <= w_acc_clr ? '0 : w_sum;
                end else begin
                    r_acc0 <= w_acc_clr ? '0 : w_sum;
                end
            end
        end
    end
`endif

    // EXEC and DONE each last exactly one cycle, so grant/done decode from state.
    assign gnt0    = (r_state == S_EXEC) & ~r_id;
    assign gnt1    = (r_state == S_EXEC) &  r_id;
    assign done    = (r_state == S_DONE);
    assign done_id = r_done_id;
    assign result  = r_result;
    assign cout    = r_cout;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_compute_scheduler.sv
// ============================================================================
// Module      : tb_compute_scheduler
// Description : Self-checking bench for compute_scheduler with a cycle-level
//               transaction model; honours COMPUTE_SCHED_MAC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compute_scheduler;
    import compute_sched_pkg::*;

`ifdef COMPUTE_SCHED_MAC_EN
    localparam bit MAC_EN = 1'b1;
`else
    localparam bit MAC_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       req0 = 0, req1 = 0;
    logic [1:0] op0 = 0, op1 = 0;
    logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic       gnt0, gnt1, done, done_id, cout, err;
    logic [7:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    compute_scheduler dut (
        .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
        .done(done), .done_id(done_id), .result(result), .cout(cout), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int k = 0, free_k = 0, gnt_edge = -1, gnt_id = 0, done_edge = -1;
    bit last = 1'b1;
    int macc [2];
    int p_id, p_res, p_cout, p_err;
    int h_id = 0, h_res = 0, h_cout = 0, h_err = 0;
    int glog [$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            free_k = 0; gnt_edge = -1; done_edge = -1; last = 1'b1;
            macc[0] = 0; macc[1] = 0;
            h_id = 0; h_res = 0; h_cout = 0; h_err = 0;
        end else begin
            k++;
            if (k == done_edge) begin
                h_id = p_id; h_res = p_res; h_cout = p_cout; h_err = p_err;
            end
            if (k >= free_k && (req0 || req1)) begin
                int w, o, a, b, lat, prod;
                w = (req0 && req1) ? int'(!last) : int'(req1);
                last = w[0];
                o = w ? op1 : op0;
                a = w ? a1 : a0;
                b = w ? b1 : b0;
                prod = (a * b) % 256;
                lat = 1; p_id = w; p_res = 0; p_cout = 0; p_err = 0;
                case (o)
                    0: begin p_res = (a + b) % 256; p_cout = (a + b) > 255; end
                    1: p_res = prod;
                    2: if (MAC_EN) begin
                           p_res = (prod + macc[w]) % 256;
                           p_cout = (prod + macc[w]) > 255;
                           macc[w] = p_res;
                           lat = 2;
                       end else p_err = 1;
                    default: if (MAC_EN) begin
                           p_res = macc[w];
                           macc[w] = 0;
                       end else p_err = 1;
                endcase
                gnt_edge = k; gnt_id = w;
                done_edge = k + lat;
                free_k = done_edge + 2;
            end
        end
    end

    always @(negedge CLK) begin
        check("gnt0",    gnt0,    int'(gnt_edge == k && gnt_id == 0));
        check("gnt1",    gnt1,    int'(gnt_edge == k && gnt_id == 1));
        check("done",    done,    int'(done_edge == k && !RST));
        check("done_id", done_id, h_id);
        check("result",  result,  h_res);
        check("cout",    cout,    h_cout);
        check("err",     err,     h_err);
        if (gnt0) glog.push_back(0);
        if (gnt1) glog.push_back(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int id, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin req0 = 1; op0 = o; a0 = a; b0 = b; end
        else         begin req1 = 1; op1 = o; a1 = a; b1 = b; end
    endtask

    task automatic drop(input int id);
        if (id == 0) req0 = 0; else req1 = 0;
    endtask

    task automatic wait_gnt(input int id, output bit got);
        got = 0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge CLK);
            got = (id == 0) ? gnt0 : gnt1;
        end
        if (!got) check("gnt_timeout", 0, 1);
    endtask

    task automatic run_op(input int id, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int e_res, input int e_cout, input int e_err, input string name);
        bit got;
        int lat;
        drive(id, o, a, b);
        wait_gnt(id, got);
        drop(id);
        lat = 0;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge CLK);
            lat++;
            got = done;
        end
        check({name, "_done_seen"}, int'(got), 1);
        check({name, "_latency"}, lat, (o == OP_MAC && MAC_EN) ? 2 : 1);
        check({name, "_result"}, result, e_res);
        check({name, "_cout"}, cout, e_cout);
        check({name, "_err"}, err, e_err);
        check({name, "_done_id"}, done_id, id);
    endtask

    task automatic requester(input int id, input int n, input bit rnd);
        bit got;
        for (int i = 0; i < n; i++) begin
            if (rnd) repeat ($urandom_range(0, 4)) @(negedge CLK);
            drive(id, rnd ? 2'($urandom_range(0, 3)) : OP_ADD, 8'($urandom), 8'($urandom));
            wait_gnt(id, got);
            drop(id);
            @(negedge CLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        RST = 1'b0;
        @(negedge CLK);

        run_op(0, OP_ADD, 8'd9,   8'd13,  22, 0, 0, "add_9_13");
        run_op(1, OP_MUL, 8'd15,  8'd16, 240, 0, 0, "mul_15_16");
        run_op(1, OP_MUL, 8'd16,  8'd16,   0, 0, 0, "mul_16_16");
        run_op(1, OP_MUL, 8'd17,  8'd16,  16, 0, 0, "mul_17_16");
        run_op(0, OP_ADD, 8'd200, 8'd100, 44, 1, 0, "add_carry");
`ifdef COMPUTE_SCHED_MAC_EN
        run_op(0, OP_MAC,   8'd3, 8'd5, 15, 0, 0, "mac_3_5");
        run_op(0, OP_MAC,   8'd4, 8'd4, 31, 0, 0, "mac_4_4");
        run_op(0, OP_RDCLR, 8'd0, 8'd0, 31, 0, 0, "rdclr_31");
        run_op(0, OP_RDCLR, 8'd0, 8'd0,  0, 0, 0, "rdclr_0");
        run_op(1, OP_RDCLR, 8'd0, 8'd0,  0, 0, 0, "rdclr_acc1");
        run_op(0, OP_MAC,   8'd2, 8'd3,  6, 0, 0, "mac_pre0");
        run_op(1, OP_MAC,   8'd7, 8'd7, 49, 0, 0, "mac_pre1");
`else
        run_op(0, OP_MAC,   8'd3, 8'd5, 0, 0, 1, "mac_err");
        run_op(1, OP_RDCLR, 8'd9, 8'd9, 0, 0, 1, "rdclr_err");
`endif

        // Contention: both raise on the same edge, two requests each
        glog.delete();
        fork
            requester(0, 2, 1'b0);
            requester(1, 2, 1'b0);
        join
        repeat (4) @(negedge CLK);
        check("contention_count", glog.size(), 4);
        if (glog.size() == 4) begin
            check("contention_g0", glog[0], 0);
            check("contention_g1", glog[1], 1);
            check("contention_g2", glog[2], 0);
            check("contention_g3", glog[3], 1);
        end

        // Reset during EXEC of a MAC
        drive(0, OP_MAC, 8'd5, 8'd5);
        wait_gnt(0, got);
        RST = 1'b1;
        drop(0);
        #1;
        check("rst_mid_done", done, 0);
        check("rst_mid_result", result, 0);
        @(negedge CLK);
        RST = 1'b0;
        got = 0;
        repeat (4) begin
            @(negedge CLK);
            if (done) got = 1;
        end
        check("rst_no_done", int'(got), 0);
`ifdef COMPUTE_SCHED_MAC_EN
        run_op(0, OP_RDCLR, 8'd0, 8'd0, 0, 0, 0, "acc0_cleared");
        run_op(1, OP_RDCLR, 8'd0, 8'd0, 0, 0, 0, "acc1_cleared");
`endif
        run_op(0, OP_ADD, 8'd1, 8'd1, 2, 0, 0, "add_after_rst");

        fork
            requester(0, 30, 1'b1);
            requester(1, 30, 1'b1);
        join
        repeat (6) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/compute_scheduler.md
# compute_scheduler

Two-requester scheduler that shares the single `eight_bit_multiplier_module` and `eight_bit_full_adder_module` between two clients. It performs ADD, MUL, multiply-accumulate and accumulator read/clear. It arbitrates round-robin, sequences each operation through the shared datapath with a small FSM, and returns a registered 8-bit result with a one-cycle `done` strobe. It sits between the control blocks and the arithmetic units.

## Interface
- Parameters: none. Width is fixed at 8 bits to match the shared adder and multiplier.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: operation request, one per requester.
- `op0`, `op1` in 2: opcode. 00 ADD, 01 MUL, 10 MAC, 11 RDCLR.
- `a0`, `b0`, `a1`, `b1` in 8: operands per requester.
- `gnt0`, `gnt1` out 1: one-cycle grant. Operands are captured on the edge that raises it.
- `done` out 1: one-cycle result strobe.
- `done_id` out 1: requester that owns the current result.
- `result` out 8: registered result, valid while `done` is high.
- `cout` out 1: adder carry for ADD and MAC, else 0.
- `err` out 1: illegal op, valid with `done`.

## Operation
- FSM states: IDLE, EXEC, ACC, DONE. Reset state is IDLE.
- IDLE:
  - If any `req` is high, pick a winner and capture `op`, `a`, `b` and id.
  - Assert that requester's `gnt` for exactly one cycle, then go to EXEC.
- EXEC:
  - ADD: `r <= a+b` (cin=0), `cout` is the adder carry → DONE.
  - MUL: `r <=` low 8 bits of the product, `cout`=0 → DONE.
  - MAC: `p <=` low 8 bits of the product → ACC.
  - RDCLR: `r <= acc[id]`, `acc[id] <= 0` → DONE.
- ACC: `r <= p + acc[id]`, `acc[id] <=` the same sum, `cout` is the adder carry → DONE.
- DONE: `done`=1 and `done_id`=id for one cycle → IDLE.
- Arithmetic: all results truncate modulo 256; the overflow indication is `cout` only. Each requester has a private 8-bit accumulator `acc0`/`acc1`, reset to 0.
- Arbitration:
  - Exactly one requester high: it wins.
  - Both high: the requester not granted last wins.
  - The last-grant register resets to 1, so requester 0 wins the first tie.
- Requester rules:
  - Hold `req`, `op` and operands stable until `gnt` is seen.
  - Drop `req` on the edge after `gnt`.
  - `req` is sampled only in IDLE; a `req` still high there is a new request.

## Timing
- Reset values: `gnt0`/`gnt1`/`done`/`done_id`/`cout`/`err` = 0, `result` = 0, accumulators = 0, state = IDLE, last-grant = 1.
- Latency, with the request sampled at edge E0:
  - `gnt` is high during E0→E1.
  - ADD/MUL/RDCLR: `done` is high during E1→E2.
  - MAC: `done` is high during E2→E3.
- Throughput: the next grant comes no earlier than the edge after DONE. Minimum spacing is 3 cycles for ADD/MUL and 4 cycles for MAC.
- Both requests arriving simultaneously: they are serviced back-to-back, alternating.
- `RST` mid-operation: outputs and accumulators clear immediately. The in-flight op is discarded and no `done` is issued.
- `result`, `cout`, `err` and `done_id` hold their values after DONE until the next DONE.

## Configuration
- Macro: `COMPUTE_SCHED_MAC_EN`.
- Defined: MAC and RDCLR are implemented as above, with the ACC state and both accumulators.
- Undefined:
  - No accumulators and no ACC state.
  - Ops 10 and 11 go EXEC→DONE with `err`=1, `result`=0, `cout`=0.
  - ADD and MUL are unchanged.

## Structure
- Package `compute_sched_pkg` holds:
  - Opcode constants OP_ADD/OP_MUL/OP_MAC/OP_RDCLR.
  - FSM state encoding.
  - The 8-bit data width constant.
- Sub-module `rr_arbiter2` is the two-way round-robin picker. Inputs: `req0`, `req1`, last-grant. Outputs: winner valid, winner id.
- Instantiate `eight_bit_full_adder_module` (cin tied 0) and `eight_bit_multiplier_module` exactly once each. The scheduler muxes their inputs per state.

## Test plan
- Single ADD: req0, a0=9, b0=13 → `gnt0` one cycle, `done` 2 edges after the request edge, `result`=22, `cout`=0, `done_id`=0.
- MUL truncation on requester 1:
  - 15×16 → 240.
  - 16×16 → 0.
  - 17×16 → 16.
  - `cout`=0 in every case.
- ADD carry: 200+100 → `result`=44, `cout`=1.
- MAC sequence on requester 0:
  - MAC 3×5 → 15.
  - MAC 4×4 → 31.
  - RDCLR → 31.
  - RDCLR → 0.
  - Requester 1's accumulator is untouched throughout.
- Contention: `req0` and `req1` high on the same edge, held for 4 requests total → grants alternate 0,1,0,1, with `done_id` matching each grant.
- `RST` asserted during EXEC of a MAC → no `done`, accumulators 0; the next ADD 1+1 returns 2. With the macro undefined, op 10 returns `err`=1, `result`=0.
